// File: rtl/move_pulse_gen.sv
// move_pulse_gen
//
// Turns held left/right direction levels into single-cycle move pulses with
// keyboard-style auto-repeat: one pulse on press, a second pulse HOLD_DELAY
// cycles later, then one pulse every REPEAT_PERIOD cycles while the key stays
// held. Pressing both directions, or pausing the game, locks the generator out
// until every key is released.
//
// Parameters
//   HOLD_DELAY     cycles from the first pulse to the first auto-repeat pulse
//   REPEAT_PERIOD  cycles between successive auto-repeat pulses
//   CW             counter width. HOLD_DELAY and REPEAT_PERIOD must each be
//                  in the range 2 .. 2^CW.
//
// Ports
//   clk         system clock. All logic runs on its rising edge.
//   reset       synchronous, active-high reset
//   left_in     level, left direction held. Already synchronous to clk.
//   right_in    level, right direction held. Already synchronous to clk.
//   enable      high while the game is running. Low suppresses all moves.
//   step_left   registered one-cycle pulse that moves the player left
//   step_right  registered one-cycle pulse that moves the player right
//   state_o     current FSM state encoding, for LEDs and debug

module move_pulse_gen #(
    parameter int HOLD_DELAY    = 15000000,
    parameter int REPEAT_PERIOD = 7500000,
    parameter int CW            = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_in,
    input  logic       right_in,
    input  logic       enable,
    output logic       step_left,
    output logic       step_right,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        REPEAT  = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // The counter runs from 0 up to the last value before a pulse.
    // Because it is cleared whenever a pulse fires, the spacing between pulses
    // comes out to exactly HOLD_DELAY or REPEAT_PERIOD cycles.
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_DELAY - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_PERIOD - 1);

    state_t        state_q, state_n;
    logic          dir_q, dir_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          pulse_left, pulse_right;
    logic          dir_held;
    logic          both_held;

    // dir is 0 for left and 1 for right.
    // dir_held reports whether the key that started the current press is
    // still down.
    assign dir_held  = dir_q ? right_in : left_in;
    assign both_held = left_in & right_in;

    // State register. The step outputs are registered here as well, so a
    // condition sampled on one edge drives its pulse until the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            cnt_q      <= '0;
            step_left  <= 1'b0;
            step_right <= 1'b0;
        end else begin
            state_q    <= state_n;
            dir_q      <= dir_n;
            cnt_q      <= cnt_n;
            step_left  <= pulse_left;
            step_right <= pulse_right;
        end
    end

    // Next-state logic. A paused game has priority over everything else.
    // Next comes a two-key conflict. Only after those does each state apply
    // its own rules.
    always_comb begin
        state_n = state_q;
        dir_n   = dir_q;
        cnt_n   = cnt_q;

        if (!enable) begin
            state_n = LOCKOUT;
            cnt_n   = '0;
        end else if (both_held) begin
            state_n = LOCKOUT;
            cnt_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_n = '0;
                    if (left_in) begin
                        dir_n   = 1'b0;
                        state_n = DELAY;
                    end else if (right_in) begin
                        dir_n   = 1'b1;
                        state_n = DELAY;
                    end
                end

                // When the key is released, the generator returns to IDLE
                // even if the opposite key was pressed on the same edge. That
                // opposite press is then seen as a fresh press from IDLE.
                DELAY: begin
                    if (!dir_held) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_n = REPEAT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end

                REPEAT: begin
                    if (!dir_held) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else if (cnt_q == REPEAT_LAST) begin
                        cnt_n = '0;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end

                LOCKOUT: begin
                    cnt_n = '0;
                    if (!left_in && !right_in) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Output logic. This decides whether the upcoming edge fires a pulse.
    // A pulse fires on a fresh press from IDLE, or when the hold or repeat
    // counter reaches its terminal value. At most one direction is ever
    // selected at a time.
    always_comb begin
        pulse_left  = 1'b0;
        pulse_right = 1'b0;

        if (enable && !both_held) begin
            case (state_q)
                IDLE: begin
                    if (left_in) begin
                        pulse_left = 1'b1;
                    end else if (right_in) begin
                        pulse_right = 1'b1;
                    end
                end

                DELAY: begin
                    if (dir_held && cnt_q == HOLD_LAST) begin
                        pulse_left  = ~dir_q;
                        pulse_right = dir_q;
                    end
                end

                REPEAT: begin
                    if (dir_held && cnt_q == REPEAT_LAST) begin
                        pulse_left  = ~dir_q;
                        pulse_right = dir_q;
                    end
                end

                default: begin
                    pulse_left  = 1'b0;
                    pulse_right = 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_move_pulse_gen.sv
// tb_move_pulse_gen
//
// Scoreboard bench for move_pulse_gen, using HOLD_DELAY=4, REPEAT_PERIOD=2
// and CW=4.
//
// The stimulus process drives inputs on the falling edge and pushes the
// hand-computed pulses it expects into a queue. Each entry holds the rising
// edge number that should launch the pulse and the pulse direction.
//
// A separate monitor samples the outputs on every falling edge. It pops and
// compares an entry whenever a pulse is present. It also flags any expectation
// that went stale without a matching pulse.

module tb_move_pulse_gen;

    typedef struct {
        int edge_no;
        bit dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       left_in;
    logic       right_in;
    logic       enable;
    logic       step_left;
    logic       step_right;
    logic [1:0] state_o;

    int   cyc          = 0;
    int   assert_count = 0;
    int   fail_count   = 0;
    exp_t exp_q[$];

    move_pulse_gen #(
        .HOLD_DELAY   (4),
        .REPEAT_PERIOD(2),
        .CW           (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .left_in   (left_in),
        .right_in  (right_in),
        .enable    (enable),
        .step_left (step_left),
        .step_right(step_right),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor. It retires stale expectations first, then matches any pulse
    // that is present against the oldest expectation in the queue.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].edge_no < cyc) begin
            e = exp_q.pop_front();
            assert_count++;
            fail_count++;
            $display("[TB] FAIL missed_pulse: no pulse seen, expected dir %0d at edge %0d", e.dir, e.edge_no);
        end

        assert_count++;
        if (step_left && step_right) begin
            fail_count++;
            $display("[TB] FAIL both_steps: step_left=%0b step_right=%0b at edge %0d, expected never both high",
                     step_left, step_right, cyc);
        end

        if (step_left || step_right) begin
            assert_count++;
            if (exp_q.size() == 0) begin
                fail_count++;
                $display("[TB] FAIL unexpected_pulse: step_left=%0b step_right=%0b at edge %0d, expected none",
                         step_left, step_right, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.edge_no != cyc || e.dir != step_right) begin
                    fail_count++;
                    $display("[TB] FAIL pulse: got dir %0d at edge %0d, expected dir %0d at edge %0d",
                             step_right, cyc, e.dir, e.edge_no);
                end
            end
        end
    end

    // Watchdog so that the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic expectPulse(input int edge_no, input bit dir);
        exp_t e;
        e.edge_no = edge_no;
        e.dir     = dir;
        exp_q.push_back(e);
    endtask

    // Drives the inputs on a falling edge, then holds them for n rising edges.
    // The task returns on the falling edge after the last of those rising edges.
    task automatic applyStimulus(input logic l, input logic r, input logic en,
                                 input logic rst, input int n);
        left_in  = l;
        right_in = r;
        enable   = en;
        reset    = rst;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp_state);
        assert_count++;
        if (state_o !== exp_state) begin
            fail_count++;
            $display("[TB] FAIL %s: state_o=%0d, expected %0d", name, state_o, exp_state);
        end
    endtask

    task automatic checkSteps(input string name);
        assert_count++;
        if (step_left !== 1'b0 || step_right !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL %s: step_left=%0b step_right=%0b, expected 0 0", name, step_left, step_right);
        end
    endtask

    initial begin
        int c;
        reset    = 1'b1;
        enable   = 1'b1;
        left_in  = 1'b0;
        right_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 2'd0);
        checkSteps("reset_steps");
        applyStimulus(0, 0, 1, 0, 2);
        checkOutput("idle_after_reset", 2'd0);

        // Tap: one left pulse, then back to IDLE
        $display("[TB] tap");
        c = cyc;
        expectPulse(c + 1, 1'b0);
        applyStimulus(1, 0, 1, 0, 1);
        checkOutput("tap_delay", 2'd1);
        applyStimulus(0, 0, 1, 0, 3);
        checkOutput("tap_idle", 2'd0);

        // Hold right for 12 cycles: pulses at relative edges 1, 5, 7, 9, 11
        $display("[TB] hold");
        c = cyc;
        expectPulse(c + 1, 1'b1);
        expectPulse(c + 5, 1'b1);
        expectPulse(c + 7, 1'b1);
        expectPulse(c + 9, 1'b1);
        expectPulse(c + 11, 1'b1);
        applyStimulus(0, 1, 1, 0, 6);
        checkOutput("hold_repeat", 2'd2);
        applyStimulus(0, 1, 1, 0, 6);
        applyStimulus(0, 0, 1, 0, 3);
        checkOutput("hold_idle", 2'd0);

        // Conflict: left held, then right joins, which locks the generator out
        $display("[TB] conflict");
        c = cyc;
        expectPulse(c + 1, 1'b0);
        applyStimulus(1, 0, 1, 0, 3);
        applyStimulus(1, 1, 1, 0, 4);
        checkOutput("conflict_lock", 2'd3);
        applyStimulus(1, 0, 1, 0, 2);
        checkOutput("conflict_lock_left", 2'd3);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("conflict_release", 2'd0);
        c = cyc;
        expectPulse(c + 1, 1'b1);
        applyStimulus(0, 1, 1, 0, 1);
        applyStimulus(0, 0, 1, 0, 3);

        // Swap: in DELAY, left drops as right rises
        $display("[TB] swap");
        c = cyc;
        expectPulse(c + 1, 1'b0);
        applyStimulus(1, 0, 1, 0, 2);
        expectPulse(c + 4, 1'b1);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("swap_idle", 2'd0);
        applyStimulus(0, 1, 1, 0, 1);
        checkOutput("swap_delay", 2'd1);
        applyStimulus(0, 0, 1, 0, 3);

        // Pause while in REPEAT, then resume with the key still held
        $display("[TB] pause");
        c = cyc;
        expectPulse(c + 1, 1'b0);
        expectPulse(c + 5, 1'b0);
        expectPulse(c + 7, 1'b0);
        applyStimulus(1, 0, 1, 0, 7);
        applyStimulus(1, 0, 0, 0, 3);
        checkOutput("pause_lock", 2'd3);
        applyStimulus(1, 0, 1, 0, 3);
        checkOutput("resume_held", 2'd3);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("resume_release", 2'd0);
        c = cyc;
        expectPulse(c + 1, 1'b0);
        applyStimulus(1, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 0, 3);

        // Reset pulsed during REPEAT with left held
        $display("[TB] reset mid-hold");
        c = cyc;
        expectPulse(c + 1, 1'b0);
        expectPulse(c + 5, 1'b0);
        expectPulse(c + 7, 1'b0);
        applyStimulus(1, 0, 1, 0, 8);
        checkOutput("pre_reset_repeat", 2'd2);
        applyStimulus(1, 0, 1, 1, 1);
        checkOutput("mid_reset_state", 2'd0);
        checkSteps("mid_reset_steps");
        applyStimulus(1, 0, 1, 1, 1);
        c = cyc;
        expectPulse(c + 1, 1'b0);
        applyStimulus(1, 0, 1, 0, 1);
        checkOutput("post_reset_delay", 2'd1);
        applyStimulus(0, 0, 1, 0, 4);
        checkOutput("final_idle", 2'd0);

        assert_count++;
        if (exp_q.size() != 0) begin
            fail_count++;
            $display("[TB] FAIL pending_pulses: %0d expected pulses never seen, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/move_pulse_gen.md
MOVE_PULSE_GEN -- requirements
Module: move_pulse_gen

Interface
REQ-001 Parameter HOLD_DELAY, default 15000000, cycles from the first pulse to the first auto-repeat pulse (300 ms at 50 MHz).
REQ-002 Parameter REPEAT_PERIOD, default 7500000, cycles between successive auto-repeat pulses (150 ms at 50 MHz).
REQ-003 Parameter CW, default 25, counter width; HOLD_DELAY and REPEAT_PERIOD each SHALL be >= 2 and <= 2^CW.
REQ-004 clk  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 left_in  input  1  level, left direction held (keyboard-decoder flag OR synchronized button), already synchronous to clk.
REQ-007 right_in  input  1  level, right direction held, already synchronous to clk.
REQ-008 enable  input  1  high = game running; low = pause/game-over, moves suppressed.
REQ-009 step_left  output  1  registered single-cycle pulse, feeds player move_left.
REQ-010 step_right  output  1  registered single-cycle pulse, feeds player move_right.
REQ-011 state_o  output  2  current FSM state encoding, for LEDs/debug.

Function
REQ-012 The FSM SHALL have states IDLE=0, DELAY=1, REPEAT=2, LOCKOUT=3, plus a 1-bit latched direction dir (0=left, 1=right) and a CW-bit counter cnt.
REQ-013 step_left and step_right SHALL never be high in the same cycle, and each pulse SHALL last exactly one cycle.
REQ-014 Latency: an input condition sampled at edge N that causes a pulse SHALL drive the pulse high from edge N to edge N+1.
REQ-015 Precedence in every state: enable low overrides all other conditions, then both inputs high, then the per-state rules.
REQ-016 In any state, enable low SHALL force LOCKOUT, clear cnt, and emit no pulse.
REQ-017 IDLE, enable high, exactly one input high: emit a pulse in that direction, latch dir, clear cnt, go to DELAY.
REQ-018 IDLE, both inputs high: no pulse, go to LOCKOUT.
REQ-019 IDLE, no input high: remain in IDLE.
REQ-020 DELAY and REPEAT: if the input for the latched dir is low, go to IDLE with no pulse and clear cnt, even if the opposite input rose in the same cycle; the opposite input is then handled from IDLE on the next edge.
REQ-021 DELAY and REPEAT: if both inputs are high, go to LOCKOUT with no pulse.
REQ-022 DELAY, dir input still held: increment cnt. When cnt == HOLD_DELAY-1: emit a pulse in dir, clear cnt, go to REPEAT.
REQ-023 REPEAT, dir input still held: increment cnt. When cnt == REPEAT_PERIOD-1: emit a pulse in dir, clear cnt, stay in REPEAT.
REQ-024 Resulting pulse spacing: first to second pulse = HOLD_DELAY cycles; each later pair = REPEAT_PERIOD cycles.
REQ-025 LOCKOUT: no pulses. Go to IDLE only when enable is high and both inputs are low; cnt held at 0.
REQ-026 cnt SHALL never exceed the active terminal value and SHALL never wrap.
REQ-027 state_o SHALL equal the registered state encoding of REQ-012.

Reset
REQ-028 While reset is high at a clock edge: state=IDLE, dir=0, cnt=0, step_left=0, step_right=0, state_o=0.
REQ-029 Reset asserted mid-hold SHALL abort the sequence with no pulse. After reset releases, an input still held SHALL be treated as a new press from IDLE, producing a pulse per REQ-014.

Verification (bench parameters HOLD_DELAY=4, REPEAT_PERIOD=2, enable=1 unless stated)
REQ-030 Tap: left_in high for 1 cycle from idle -> exactly one step_left pulse, one cycle later; state returns to IDLE; no step_right.
REQ-031 Hold: right_in high for 12 cycles -> step_right pulses at relative cycles 1, 5, 7, 9, 11 (first at 1, then +4, then every +2); none after release.
REQ-032 Conflict: left_in held 3 cycles, then right_in also rises -> no further pulses, state_o=3; only after both drop does a new right_in press give a pulse.
REQ-033 Swap: in DELAY with left held, left drops and right rises on the same edge -> no pulse that cycle, step_right exactly 2 cycles after the swap edge.
REQ-034 Pause: enable low while left held in REPEAT -> no pulses, state_o=3; enable high again with left still held -> still no pulse until left is released and re-pressed.
REQ-035 Reset: reset pulsed during REPEAT with left held -> outputs 0 and state_o=0 during reset; first step_left one cycle after reset deasserts.
